freq_gate_ctrl: RTL and testbench

Gate-time sequencer and measurement controller for the frequency counter. It synchronises the external `signal` input and counts its rising edges inside a fixed gate window. At the end of the window it converts the count to four packed BCD digits with a sequential double-dabble engine. It then hands the result, with a one-cycle valid strobe, to the 7-segment display driver that produces `Seg`/`Dig`.

---
 rtl/freq_gate_ctrl.sv | 147 ++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// Gate-time sequencer for the frequency counter: counts synchronised rising edges of
// `signal` over a fixed window, then converts the count to packed BCD by double-dabble.
module freq_gate_ctrl #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned CNT_MAX     = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        signal,
  input  logic        enable,
  output logic [15:0] bcd,
  output logic        valid,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GATE, CONV, DONE} state_e;

  localparam logic [26:0] GATE_LAST = 27'(GATE_CYCLES - 1);
  localparam logic [13:0] CNT_SAT   = 14'(CNT_MAX);
  localparam logic [3:0]  ITER_LAST = 4'd13;

  state_e      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic        edge_w;
  logic [26:0] gate_cnt_q, gate_cnt_d;
  logic [13:0] edge_cnt_q, edge_cnt_d;
  logic        ovf_q, ovf_d;
  logic [29:0] shift_q, shift_d;
  logic [29:0] dabble_w;
  logic [15:0] adj_w;
  logic [3:0]  iter_q, iter_d;
  logic [15:0] bcd_q, bcd_d;
  logic        overflow_q, overflow_d;

  assign edge_w = s2_q & ~s3_q;

  // One double-dabble step: bias every BCD nibble >= 5 by 3, then shift the whole register.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    assign adj_w[gi*4 +: 4] = (shift_q[14 + gi*4 +: 4] >= 4'd5) ?
                              shift_q[14 + gi*4 +: 4] + 4'd3 :
                              shift_q[14 + gi*4 +: 4];
  end
  assign dabble_w = {adj_w, shift_q[13:0]} << 1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort has priority over the end of the gate window
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable) state_d = GATE;
      GATE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (gate_cnt_q == GATE_LAST) begin
          state_d = CONV;
        end
      end
      CONV: if (iter_q == ITER_LAST) state_d = DONE;
      DONE: state_d = enable ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (state_q != IDLE);
    valid    = (state_q == DONE);
    bcd      = bcd_q;
    overflow = overflow_q;
  end

  always_comb begin
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    shift_d    = shift_q;
    iter_d     = iter_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      GATE: begin
        gate_cnt_d = (state_d == GATE) ? gate_cnt_q + 27'd1 : 27'd0;
        if (edge_w) begin
          if (edge_cnt_q >= CNT_SAT) begin
            ovf_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + 14'd1;
          end
        end
        // Load includes an edge seen in the final gate cycle
        if (state_d == CONV) begin
          shift_d = {16'd0, edge_cnt_d};
          iter_d  = 4'd0;
        end
      end
      CONV: begin
        shift_d = dabble_w;
        iter_d  = iter_q + 4'd1;
        if (iter_q == ITER_LAST) begin
          bcd_d      = dabble_w[29:14];
          overflow_d = ovf_q;
        end
      end
      default: begin
        gate_cnt_d = 27'd0;
        edge_cnt_d = 14'd0;
        ovf_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      gate_cnt_q <= 27'd0;
      edge_cnt_q <= 14'd0;
      ovf_q      <= 1'b0;
      shift_q    <= 30'd0;
      iter_q     <= 4'd0;
      bcd_q      <= 16'h0000;
      overflow_q <= 1'b0;
    end else begin
      s1_q       <= signal;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      shift_q    <= shift_d;
      iter_q     <= iter_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Scoreboard bench for freq_gate_ctrl: a short-gate instance for timing/abort/reset cases
// and a long-gate instance for saturation.
module tb_freq_gate_ctrl;

  logic clk;
  logic reset_a, signal_a, enable_a;
  logic [15:0] bcd_a;
  logic valid_a, overflow_a, busy_a;
  logic reset_b, signal_b, enable_b;
  logic [15:0] bcd_b;
  logic valid_b, overflow_b, busy_b;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int mode_a   = 1;
  int mode_b   = 0;
  int ph_a     = 0;
  int ph_b     = 0;

  logic [16:0] exp_q_a[$];
  logic [16:0] exp_q_b[$];
  logic [16:0] e_a, e_b;

  freq_gate_ctrl #(.GATE_CYCLES(100), .CNT_MAX(9999)) u_dut_a (
    .clk(clk), .reset(reset_a), .signal(signal_a), .enable(enable_a),
    .bcd(bcd_a), .valid(valid_a), .overflow(overflow_a), .busy(busy_a)
  );

  freq_gate_ctrl #(.GATE_CYCLES(30000), .CNT_MAX(9999)) u_dut_b (
    .clk(clk), .reset(reset_b), .signal(signal_b), .enable(enable_b),
    .bcd(bcd_b), .valid(valid_b), .overflow(overflow_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signal generators: 0 = low, 1 = toggle each cycle, 2 = 10 high / 10 low, 3 = manual
  initial begin
    signal_a = 1'b0;
    forever begin
      @(negedge clk);
      case (mode_a)
        0: signal_a = 1'b0;
        1: signal_a = ~signal_a;
        2: begin
          ph_a = (ph_a == 19) ? 0 : ph_a + 1;
          signal_a = (ph_a < 10);
        end
        default: ;
      endcase
    end
  end

  initial begin
    signal_b = 1'b0;
    forever begin
      @(negedge clk);
      case (mode_b)
        0: signal_b = 1'b0;
        1: signal_b = ~signal_b;
        2: begin
          ph_b = (ph_b == 19) ? 0 : ph_b + 1;
          signal_b = (ph_b < 10);
        end
        default: ;
      endcase
    end
  end

  // Scoreboard monitors: every valid pulse must match the oldest expected result
  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      if (exp_q_a.size() == 0) begin
        check_val("unexpected_valid_a", 32'd1, 32'd0);
      end else begin
        e_a = exp_q_a.pop_front();
        check_val("bcd_a", {16'd0, bcd_a}, {16'd0, e_a[15:0]});
        check_val("ovf_a", {31'd0, overflow_a}, {31'd0, e_a[16]});
        $display("txn A: bcd=%04h ovf=%0b expected bcd=%04h ovf=%0b",
                 bcd_a, overflow_a, e_a[15:0], e_a[16]);
      end
    end
    if (valid_b === 1'b1) begin
      if (exp_q_b.size() == 0) begin
        check_val("unexpected_valid_b", 32'd1, 32'd0);
      end else begin
        e_b = exp_q_b.pop_front();
        check_val("bcd_b", {16'd0, bcd_b}, {16'd0, e_b[15:0]});
        check_val("ovf_b", {31'd0, overflow_b}, {31'd0, e_b[16]});
        $display("txn B: bcd=%04h ovf=%0b expected bcd=%04h ovf=%0b",
                 bcd_b, overflow_b, e_b[15:0], e_b[16]);
      end
    end
  end

  task automatic wait_valid(input bit sel, input int budget, output int at_cyc);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      seen = sel ? valid_b : valid_a;
    end
    check_val(sel ? "valid_seen_b" : "valid_seen_a", {31'd0, seen}, 32'd1);
    at_cyc = cyc;
  endtask

  task automatic start_a(output int t0);
    @(posedge clk);
    #1;
    enable_a = 1'b1;
    t0 = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, c1, c2, n;
    reset_a = 1'b1;
    reset_b = 1'b1;
    enable_a = 1'b0;
    enable_b = 1'b0;

    // Reset with signal toggling and enable low
    repeat (3) begin
      @(negedge clk);
      check_val("rst_outs", {13'd0, bcd_a, valid_a, busy_a, overflow_a}, 32'd0);
    end
    @(posedge clk);
    #1 reset_a = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_val("idle_outs", {13'd0, bcd_a, valid_a, busy_a, overflow_a}, 32'd0);
    end

    // Basic count, continuous: two results 115 cycles apart
    @(posedge clk);
    #1 mode_a = 2;
    repeat (5) @(posedge clk);
    #1;
    exp_q_a.push_back({1'b0, 16'h0005});
    exp_q_a.push_back({1'b0, 16'h0005});
    enable_a = 1'b1;
    t0 = cyc;
    @(negedge clk);
    check_val("busy_before", {31'd0, busy_a}, 32'd0);
    @(negedge clk);
    check_val("busy_rise", {31'd0, busy_a}, 32'd1);
    wait_valid(1'b0, 300, c1);
    check_val("first_latency", c1 - t0, 32'd115);
    wait_valid(1'b0, 300, c2);
    enable_a = 1'b0;
    check_val("period", c2 - c1, 32'd115);

    // Single edge landing in the final gate cycle is counted
    mode_a = 3;
    signal_a = 1'b0;
    repeat (5) @(posedge clk);
    exp_q_a.push_back({1'b0, 16'h0001});
    start_a(t0);
    repeat (98) @(posedge clk);
    #1 signal_a = 1'b1;
    wait_valid(1'b0, 300, c1);
    enable_a = 1'b0;
    signal_a = 1'b0;

    // Edge one cycle later falls in CONV and is dead time
    repeat (5) @(posedge clk);
    exp_q_a.push_back({1'b0, 16'h0000});
    start_a(t0);
    repeat (99) @(posedge clk);
    #1 signal_a = 1'b1;
    wait_valid(1'b0, 300, c1);
    enable_a = 1'b0;
    signal_a = 1'b0;

    // Max rate
    mode_a = 1;
    repeat (5) @(posedge clk);
    exp_q_a.push_back({1'b0, 16'h0050});
    start_a(t0);
    wait_valid(1'b0, 300, c1);
    enable_a = 1'b0;

    // Abort at gate cycle 50
    mode_a = 2;
    repeat (5) @(posedge clk);
    start_a(t0);
    repeat (51) @(posedge clk);
    #1 enable_a = 1'b0;
    @(negedge clk);
    check_val("abort50_busy_hold", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    check_val("abort50_busy_fall", {31'd0, busy_a}, 32'd0);
    repeat (130) @(posedge clk);
    #1;
    check_val("abort50_bcd_keep", {16'd0, bcd_a}, 32'h0050);

    // Abort in the final gate cycle wins over completion
    start_a(t0);
    repeat (100) @(posedge clk);
    #1 enable_a = 1'b0;
    @(negedge clk);
    check_val("abortlast_busy_hold", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    check_val("abortlast_busy_fall", {31'd0, busy_a}, 32'd0);
    repeat (130) @(posedge clk);
    #1;
    check_val("abortlast_bcd_keep", {16'd0, bcd_a}, 32'h0050);
    check_val("abortlast_ovf_keep", {31'd0, overflow_a}, 32'd0);

    // Reset during CONV, then clean restart with enable held high
    start_a(t0);
    repeat (105) @(posedge clk);
    #1 reset_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_outs", {13'd0, bcd_a, valid_a, busy_a, overflow_a}, 32'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ph_a != 12 && n < 40);
    check_val("midrst_phase", ph_a, 32'd12);
    exp_q_a.push_back({1'b0, 16'h0005});
    reset_a = 1'b0;
    t0 = cyc;
    wait_valid(1'b0, 300, c1);
    enable_a = 1'b0;
    check_val("restart_latency", c1 - t0, 32'd115);

    // Long gate: saturation, then a normal run clears overflow
    reset_b = 1'b0;
    mode_b = 1;
    repeat (5) @(posedge clk);
    #1;
    exp_q_b.push_back({1'b1, 16'h9999});
    enable_b = 1'b1;
    wait_valid(1'b1, 30200, c1);
    enable_b = 1'b0;
    mode_b = 2;
    repeat (5) @(posedge clk);
    #1;
    exp_q_b.push_back({1'b0, 16'h1500});
    enable_b = 1'b1;
    wait_valid(1'b1, 30200, c2);
    enable_b = 1'b0;
    check_val("period_b", c2 - c1, 32'd30020);

    repeat (5) @(posedge clk);
    #1;
    check_val("sb_empty_a", exp_q_a.size(), 32'd0);
    check_val("sb_empty_b", exp_q_b.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
